scc_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the SCC core's decode. Owns the fetch PC and drives the

---
 rtl/scc_pkg.sv | 25 ++
 rtl/scc_fetch_fifo.sv | 78 +++++++
 rtl/scc_fetch_unit.sv | 111 +++++++++++
 tb/tb_scc_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// Shared definitions for the SCC core front end: datapath widths, reset PC,
// sequential fetch step and the layout of one buffered fetch entry.
package scc_pkg;

  localparam int unsigned SCC_XLEN    = 32;
  localparam int unsigned SCC_INST_W  = 32;
  localparam logic [SCC_XLEN-1:0] SCC_RESET_PC = 32'h0000_0000;
  localparam int unsigned SCC_PC_STEP = 4;

  // A fetch entry is {pc, inst}; offsets let flat 64-bit storage be sliced.
  localparam int unsigned SCC_ENT_W        = SCC_XLEN + SCC_INST_W;
  localparam int unsigned SCC_ENT_INST_LSB = 0;
  localparam int unsigned SCC_ENT_PC_LSB   = SCC_INST_W;

  typedef struct packed {
    logic [SCC_XLEN-1:0]   pc;
    logic [SCC_INST_W-1:0] inst;
  } scc_fetch_entry_t;

  // Instructions are word aligned, so the two low address bits are dropped.
  function automatic logic [SCC_XLEN-1:0] scc_align_pc(input logic [SCC_XLEN-1:0] pc);
    return pc & ~SCC_XLEN'(3);
  endfunction

endpackage

// File: rtl/scc_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries between the
// instruction-memory response and decode. Flush wins over push and pop.
// While empty, the head output keeps showing the last value it presented.
module scc_fetch_fifo
  import scc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = SCC_ENT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     hold_q, hold_d;
  logic             do_push;
  logic             do_pop;

  // Qualify requests, advance pointers and count; flush resets everything.
  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && !flush && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  // Head shows the oldest entry, or repeats the previous head when empty.
  always_comb begin
    head   = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
    hold_d = head;
    count  = count_q;
  end

  // Pointer, count and held-head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Entry storage; never read while its slot is empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/scc_fetch_unit.sv
// Instruction fetch stage feeding SCC decode. Owns the fetch PC, issues
// requests to instruction memory, buffers returned words with their PCs and
// restarts from a new PC on redirect.
//
// Decode handshake: inst_valid is high whenever the FIFO holds an entry and
// does not depend on inst_ready; inst/inst_pc are stable while inst_valid is
// high and not accepted; a transfer happens on a rising edge where
// inst_valid && inst_ready, and the head entry is then retired exactly once.
module scc_fetch_unit
  import scc_pkg::*;
#(
  parameter int unsigned          DEPTH    = 4,
  parameter logic [SCC_XLEN-1:0]  RESET_PC = SCC_RESET_PC,
  parameter int unsigned          PC_STEP  = SCC_PC_STEP
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [SCC_XLEN-1:0]   in_mem_addr,
  output logic                  in_mem_en,
  input  logic [SCC_INST_W-1:0] in_mem,
  input  logic                  redirect_valid,
  input  logic [SCC_XLEN-1:0]   redirect_pc,
  output logic                  inst_valid,
  output logic [SCC_INST_W-1:0] inst,
  output logic [SCC_XLEN-1:0]   inst_pc,
  input  logic                  inst_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic                  run_q, run_d;
  logic                  pend_q, pend_d;
  logic [SCC_XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [SCC_XLEN-1:0]   pc_q, pc_d;

  logic [CNT_W-1:0]      fifo_count;
  logic [SCC_ENT_W-1:0]  fifo_head;
  logic [CNT_W:0]        in_flight;
  logic                  issue;
  logic                  fifo_push;
  logic                  fifo_pop;
  scc_fetch_entry_t      push_entry;

  // Issue from registered state only: entries held plus the one in flight
  // must leave room, so every response always has a FIFO slot.
  always_comb begin
    in_flight   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q};
    issue       = run_q && (in_flight < DEPTH_W);
    in_mem_en   = issue;
    in_mem_addr = fetch_pc_q;
  end

  // Next fetch PC, issued-address capture and response tracking; a redirect
  // overrides the sequential step and drops the outstanding response.
  always_comb begin
    run_d      = 1'b1;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    pend_d     = issue;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + SCC_XLEN'(PC_STEP);
      pc_d       = fetch_pc_q;
    end
    if (redirect_valid) begin
      fetch_pc_d = scc_align_pc(redirect_pc);
      pend_d     = 1'b0;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      pend_q     <= 1'b0;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
    end else begin
      run_q      <= run_d;
      pend_q     <= pend_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
    end
  end

  // Response capture and decode-side handshake.
  always_comb begin
    push_entry.pc   = pc_q;
    push_entry.inst = in_mem;
    fifo_push       = pend_q && !redirect_valid;
    inst_valid      = (fifo_count != '0);
    fifo_pop        = inst_valid && inst_ready;
    inst            = fifo_head[SCC_ENT_INST_LSB +: SCC_INST_W];
    inst_pc         = fifo_head[SCC_ENT_PC_LSB +: SCC_XLEN];
  end

  scc_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (SCC_ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .count (fifo_count),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_scc_fetch_unit.sv
// Bench for scc_fetch_unit: a registered instruction memory returning
// word = address, an expected-entry queue checked on every decode transfer,
// and one task per scenario.
module tb_scc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] in_mem_addr;
  logic        in_mem_en;
  logic [31:0] in_mem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  scc_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_mem_addr    (in_mem_addr),
    .in_mem_en      (in_mem_en),
    .in_mem         (in_mem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data one cycle after a request, garbage otherwise.
  always @(posedge clk or negedge reset) begin
    if (!reset)         in_mem <= 32'h0;
    else if (in_mem_en) in_mem <= in_mem_addr;
    else                in_mem <= 32'hDEAD_BEEF;
  end

  // Scoreboard: every decode transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, expected no transfer", inst_pc, inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({inst_pc, inst} !== e)
          begin errors++; $display("FAIL sb_entry: got pc=%h inst=%h, expected pc=%h inst=%h", inst_pc, inst, e[63:32], e[31:0]); end
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    exp_q.delete();
    repeat (2) step();
    reset = 1'b1;   // now in cycle 0 after release
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      exp_q.push_back({a, a});
    end
  endtask

  task automatic drain(input string name, input bit rand_ready);
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      inst_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget--;
    end
    inst_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries never delivered, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    step();
    checks++; if (in_mem_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", in_mem_en); end
    checks++; if (in_mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", in_mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
  endtask

  task automatic test_startup();
    do_reset();
    checks++; if (in_mem_en !== 1'b0) begin errors++; $display("FAIL start_c0_en: got %b expected 0", in_mem_en); end
    inst_ready = 1'b1;
    push_seq(32'h0, 8);
    for (int c = 1; c <= 10; c++) begin
      logic [31:0] ea;
      logic        ev;
      step();
      ea = 32'(4 * (c - 1));
      ev = (c >= 3);
      checks++; if (in_mem_en !== 1'b1) begin errors++; $display("FAIL start_en c%0d: got %b expected 1", c, in_mem_en); end
      checks++; if (in_mem_addr !== ea) begin errors++; $display("FAIL start_addr c%0d: got %h expected %h", c, in_mem_addr, ea); end
      checks++; if (inst_valid !== ev) begin errors++; $display("FAIL start_valid c%0d: got %b expected %b", c, inst_valid, ev); end
    end
    drain("start", 1'b0);
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      logic ee;
      step();
      ee = (c <= 4);
      checks++; if (in_mem_en !== ee) begin errors++; $display("FAIL full_en c%0d: got %b expected %b", c, in_mem_en, ee); end
      if (c <= 4) begin
        checks++;
        if (in_mem_addr !== 32'(4 * (c - 1)))
          begin errors++; $display("FAIL full_addr c%0d: got %h expected %h", c, in_mem_addr, 32'(4 * (c - 1))); end
      end
    end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", inst_valid); end
    checks++; if (in_mem_addr !== 32'h10) begin errors++; $display("FAIL full_next_pc: got %h expected 00000010", in_mem_addr); end
    push_seq(32'h0, 8);
    drain("full", 1'b0);
  endtask

  task automatic test_redirect_pend();
    do_reset();
    repeat (4) step();   // cycle 4: two entries held, one response pending
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    checks++; if (in_mem_addr !== 32'hC || in_mem_en !== 1'b1) begin errors++; $display("FAIL redir_c4_issue: got en=%b addr=%h expected en=1 addr=0000000c", in_mem_en, in_mem_addr); end
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    push_seq(32'h1000, 8);
    checks++; if (in_mem_addr !== 32'h1000 || in_mem_en !== 1'b1) begin errors++; $display("FAIL redir_first_addr: got en=%b addr=%h expected en=1 addr=00001000", in_mem_en, in_mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_c5_valid: got %b expected 0", inst_valid); end
    step();
    checks++; if (in_mem_addr !== 32'h1004) begin errors++; $display("FAIL redir_second_addr: got %h expected 00001004", in_mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_c6_valid: got %b expected 0", inst_valid); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1000) begin errors++; $display("FAIL redir_c7_head: got valid=%b pc=%h expected valid=1 pc=00001000", inst_valid, inst_pc); end
    drain("redir", 1'b0);
  endtask

  task automatic test_redirect_pop();
    do_reset();
    repeat (5) step();   // cycle 5: FIFO holds 0,4,8
    exp_q.push_back({32'h0, 32'h0});
    inst_ready = 1'b1;
    step();              // cycle 6: head is 4, popped together with a redirect
    exp_q.push_back({32'h4, 32'h4});
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL rpop_head: got valid=%b pc=%h expected valid=1 pc=00000004", inst_valid, inst_pc); end
    step();
    redirect_valid = 1'b0;
    push_seq(32'h2000, 8);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rpop_c7_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_pc !== 32'h4 || inst !== 32'h4) begin errors++; $display("FAIL rpop_hold: got pc=%h inst=%h expected 00000004 00000004", inst_pc, inst); end
    step();
    checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h4) begin errors++; $display("FAIL rpop_c8: got valid=%b pc=%h expected valid=0 pc=00000004", inst_valid, inst_pc); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000) begin errors++; $display("FAIL rpop_c9: got valid=%b pc=%h expected valid=1 pc=00002000", inst_valid, inst_pc); end
    drain("rpop", 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    inst_ready = 1'b1;
    step();
    checks++; if (in_mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_c1_addr: got %h expected 00000000", in_mem_addr); end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    push_seq(32'hFFFF_FFF8, 6);
    checks++; if (in_mem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0: got %h expected fffffff8", in_mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %b expected 0", inst_valid); end
    step();
    checks++; if (in_mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a1: got %h expected fffffffc", in_mem_addr); end
    step();
    checks++; if (in_mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_a2: got %h expected 00000000", in_mem_addr); end
    drain("wrap", 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) step();   // cycle 5: three entries held
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", inst_valid); end
    reset = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", inst_valid); end
    checks++; if (in_mem_en !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b expected 0", in_mem_en); end
    checks++; if (in_mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr: got %h expected 00000000", in_mem_addr); end
    checks++; if (inst_pc !== 32'h0 || inst !== 32'h0) begin errors++; $display("FAIL rmid_outs: got pc=%h inst=%h expected 0 0", inst_pc, inst); end
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++; if (in_mem_en !== 1'b1 || in_mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_restart: got en=%b addr=%h expected en=1 addr=00000000", in_mem_en, in_mem_addr); end
    push_seq(32'h0, 8);
    drain("rmid", 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    step();
    redirect_pc    = 32'h0000_4002;
    checks++; if (in_mem_addr !== 32'h3000) begin errors++; $display("FAIL b2b_first: got %h expected 00003000", in_mem_addr); end
    step();
    redirect_valid = 1'b0;
    checks++; if (in_mem_addr !== 32'h4000 || in_mem_en !== 1'b1) begin errors++; $display("FAIL b2b_last_wins: got en=%b addr=%h expected en=1 addr=00004000", in_mem_en, in_mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", inst_valid); end
    push_seq(32'h4000, 16);
    drain("b2b", 1'b1);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_full();
    test_redirect_pend();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
